// File: rtl/fadd_issue_sched.sv
// Round-robin issue scheduler for a shared fadd_fu with result-slot reservation so the
// short CVTFI path and the long standard path never land a result in the same cycle.
module fadd_issue_sched #(
    parameter int          NREQ        = 4,
    parameter int          TAG_W       = 5,
    parameter int          STD_LAT     = 7,
    parameter int          CVT_LAT     = 1,
    parameter logic [4:0]  FUNC5_ADD   = 5'd0,
    parameter logic [4:0]  FUNC5_CVTFI = 5'd5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*5-1:0]         req_func5,
    input  logic [NREQ*18-1:0]        req_op1,
    input  logic [NREQ*18-1:0]        req_op2,
    input  logic [NREQ*TAG_W-1:0]     req_tag,
    output logic                      fu_valid,
    output logic [4:0]                fu_func5,
    output logic [17:0]               fu_op1,
    output logic [17:0]               fu_op2,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [TAG_W-1:0]          rsp_tag,
    output logic                      rsp_cvt
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int NSLOT = STD_LAT + 1;

    logic [4:0]       func5_arr [NREQ];
    logic [17:0]      op1_arr   [NREQ];
    logic [17:0]      op2_arr   [NREQ];
    logic [TAG_W-1:0] tag_arr   [NREQ];
    logic [NREQ-1:0]  elig;

    logic [ID_W-1:0]  rr_reg;
    logic             fu_valid_reg;
    logic [4:0]       fu_func5_reg;
    logic [17:0]      fu_op1_reg;
    logic [17:0]      fu_op2_reg;

    // Slot k holds the op whose result appears k cycles from now; slot 0 drives rsp_*.
    logic             slot_valid_reg [NSLOT];
    logic [ID_W-1:0]  slot_id_reg    [NSLOT];
    logic             slot_cvt_reg   [NSLOT];
    logic [TAG_W-1:0] slot_tag_reg   [NSLOT];

    logic             grant_any;
    logic [ID_W-1:0]  grant_id;
    logic             grant_cvt;
    logic             cvt_slot_busy;
    int               idx;

    // A CVTFI granted now lands in slot CVT_LAT after this cycle's shift.
    assign cvt_slot_busy = slot_valid_reg[CVT_LAT+1];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign func5_arr[gi] = req_func5[gi*5 +: 5];
            assign op1_arr[gi]   = req_op1[gi*18 +: 18];
            assign op2_arr[gi]   = req_op2[gi*18 +: 18];
            assign tag_arr[gi]   = req_tag[gi*TAG_W +: TAG_W];
            assign elig[gi]      = req_valid[gi] &
                                   ((func5_arr[gi] != FUNC5_CVTFI) | ~cvt_slot_busy);
            assign req_ready[gi] = grant_any & (grant_id == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(rr_reg) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_any && elig[idx]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
        if (rst) begin
            grant_any = 1'b0;
            grant_id  = '0;
        end
    end

    assign grant_cvt = grant_any && (func5_arr[grant_id] == FUNC5_CVTFI);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_reg       <= '0;
            fu_valid_reg <= 1'b0;
            fu_func5_reg <= FUNC5_ADD;
            fu_op1_reg   <= '0;
            fu_op2_reg   <= '0;
            for (int k = 0; k < NSLOT; k++) begin
                slot_valid_reg[k] <= 1'b0;
                slot_id_reg[k]    <= '0;
                slot_cvt_reg[k]   <= 1'b0;
                slot_tag_reg[k]   <= '0;
            end
        end else begin
            if (grant_any) begin
                rr_reg <= (grant_id == ID_W'(NREQ-1)) ? '0 : grant_id + ID_W'(1);
            end
            // Idle issue never presents CVTFI: the FU derives cvtfi_valid from func5 alone.
            fu_valid_reg <= grant_any;
            fu_func5_reg <= grant_any ? func5_arr[grant_id] : FUNC5_ADD;
            fu_op1_reg   <= grant_any ? op1_arr[grant_id] : '0;
            fu_op2_reg   <= grant_any ? op2_arr[grant_id] : '0;

            for (int k = 0; k < STD_LAT; k++) begin
                slot_valid_reg[k] <= slot_valid_reg[k+1];
                slot_id_reg[k]    <= slot_id_reg[k+1];
                slot_cvt_reg[k]   <= slot_cvt_reg[k+1];
                slot_tag_reg[k]   <= slot_tag_reg[k+1];
            end
            slot_valid_reg[STD_LAT] <= 1'b0;
            slot_id_reg[STD_LAT]    <= '0;
            slot_cvt_reg[STD_LAT]   <= 1'b0;
            slot_tag_reg[STD_LAT]   <= '0;

            if (grant_any && !grant_cvt) begin
                slot_valid_reg[STD_LAT] <= 1'b1;
                slot_id_reg[STD_LAT]    <= grant_id;
                slot_cvt_reg[STD_LAT]   <= 1'b0;
                slot_tag_reg[STD_LAT]   <= tag_arr[grant_id];
            end
            if (grant_cvt) begin
                slot_valid_reg[CVT_LAT] <= 1'b1;
                slot_id_reg[CVT_LAT]    <= grant_id;
                slot_cvt_reg[CVT_LAT]   <= 1'b1;
                slot_tag_reg[CVT_LAT]   <= tag_arr[grant_id];
            end
        end
    end

    assign fu_valid  = fu_valid_reg;
    assign fu_func5  = fu_func5_reg;
    assign fu_op1    = fu_op1_reg;
    assign fu_op2    = fu_op2_reg;
    assign rsp_valid = slot_valid_reg[0];
    assign rsp_id    = slot_id_reg[0];
    assign rsp_tag   = slot_tag_reg[0];
    assign rsp_cvt   = slot_cvt_reg[0];

endmodule

// File: tb/tb_fadd_issue_sched.sv
// Directed and randomized bench for fadd_issue_sched against a due-cycle queue model
// of arbitration, issue registers and response routing.
module tb_fadd_issue_sched;

    localparam int NREQ    = 4;
    localparam int TAG_W   = 5;
    localparam int STD_LAT = 7;
    localparam int CVT_LAT = 1;
    localparam logic [4:0] F_ADD   = 5'd0;
    localparam logic [4:0] F_CVTFI = 5'd5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*5-1:0]     req_func5;
    logic [NREQ*18-1:0]    req_op1;
    logic [NREQ*18-1:0]    req_op2;
    logic [NREQ*TAG_W-1:0] req_tag;
    logic                  fu_valid;
    logic [4:0]            fu_func5;
    logic [17:0]           fu_op1;
    logic [17:0]           fu_op2;
    logic                  rsp_valid;
    logic [1:0]            rsp_id;
    logic [TAG_W-1:0]      rsp_tag;
    logic                  rsp_cvt;

    always #5 clk = ~clk;

    fadd_issue_sched #(
        .NREQ(NREQ), .TAG_W(TAG_W), .STD_LAT(STD_LAT), .CVT_LAT(CVT_LAT),
        .FUNC5_ADD(F_ADD), .FUNC5_CVTFI(F_CVTFI)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_func5(req_func5),
        .req_op1(req_op1), .req_op2(req_op2), .req_tag(req_tag),
        .fu_valid(fu_valid), .fu_func5(fu_func5), .fu_op1(fu_op1), .fu_op2(fu_op2),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_cvt(rsp_cvt)
    );

    typedef struct {
        int due;
        int id;
        bit cvt;
        int tag;
    } op_t;

    op_t         infl[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc;
    int          rr_m;
    bit          prev_rst;
    logic        exp_fv;
    logic [4:0]  exp_f5;
    logic [17:0] exp_o1;
    logic [17:0] exp_o2;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", name, cyc, obs, exp);
        end
    endtask

    function automatic bit due_taken(input int d);
        foreach (infl[k]) if (infl[k].due == d) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_req(input int i, input bit v, input logic [4:0] f,
                           input logic [17:0] a, input logic [17:0] b,
                           input logic [TAG_W-1:0] t);
        req_valid[i]             = v;
        req_func5[i*5 +: 5]      = f;
        req_op1[i*18 +: 18]      = a;
        req_op2[i*18 +: 18]      = b;
        req_tag[i*TAG_W +: TAG_W] = t;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, F_ADD, 18'd0, 18'd0, '0);
    endtask

    // One clock cycle: check everything at the falling edge, then advance the model.
    task automatic step();
        int g;
        int idx;
        int hit;
        logic [NREQ-1:0] exp_rdy;
        logic [4:0] f;
        op_t o;
        @(negedge clk);
        g = -1;
        if (!rst) begin
            for (int off = 0; off < NREQ; off++) begin
                idx = (rr_m + off) % NREQ;
                f = req_func5[idx*5 +: 5];
                // A CVTFI granted now would answer two cycles later.
                if (g < 0 && req_valid[idx] && (f != F_CVTFI || !due_taken(cyc + 1 + CVT_LAT)))
                    g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        chk("fu_valid", fu_valid, exp_fv);
        chk("fu_func5", fu_func5, exp_f5);
        chk("fu_op1", fu_op1, exp_o1);
        chk("fu_op2", fu_op2, exp_o2);

        hit = -1;
        foreach (infl[k]) if (infl[k].due == cyc) hit = k;
        chk("rsp_valid", rsp_valid, (hit >= 0));
        if (hit >= 0) begin
            chk("rsp_id", rsp_id, infl[hit].id);
            chk("rsp_tag", rsp_tag, infl[hit].tag);
            chk("rsp_cvt", rsp_cvt, infl[hit].cvt);
            $display("rsp   cyc=%0d id=%0d tag=%0d cvt=%0d", cyc, rsp_id, rsp_tag, rsp_cvt);
            infl.delete(hit);
        end else if (prev_rst) begin
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_tag", rsp_tag, 0);
            chk("rst_rsp_cvt", rsp_cvt, 0);
        end

        prev_rst = rst;
        if (rst) begin
            infl.delete();
            rr_m = 0;
            exp_fv = 1'b0; exp_f5 = F_ADD; exp_o1 = '0; exp_o2 = '0;
        end else if (g >= 0) begin
            f     = req_func5[g*5 +: 5];
            o.id  = g;
            o.cvt = (f == F_CVTFI);
            o.due = cyc + 1 + (o.cvt ? CVT_LAT : STD_LAT);
            o.tag = int'(req_tag[g*TAG_W +: TAG_W]);
            infl.push_back(o);
            rr_m   = (g + 1) % NREQ;
            exp_fv = 1'b1;
            exp_f5 = f;
            exp_o1 = req_op1[g*18 +: 18];
            exp_o2 = req_op2[g*18 +: 18];
            $display("grant cyc=%0d id=%0d func5=%0d tag=%0d", cyc, g, f, o.tag);
        end else begin
            exp_fv = 1'b0; exp_f5 = F_ADD; exp_o1 = '0; exp_o2 = '0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        clear_reqs();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_func5 = '0; req_op1 = '0; req_op2 = '0; req_tag = '0;
        @(posedge clk);
        #1;
        cyc = 0; rr_m = 0; prev_rst = 1'b1;
        exp_fv = 1'b0; exp_f5 = F_ADD; exp_o1 = '0; exp_o2 = '0;

        // Reset state
        step();
        step();
        rst = 1'b0;

        // Single FADD from requester 0
        set_req(0, 1'b1, F_ADD, 18'h1234, 18'h2abcd, 5'h15);
        step();
        idle(9);

        // All requesters streaming FADD back-to-back
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'b1, F_ADD, 18'(i * 1000 + 7), 18'(i * 77 + 3), 5'(i * 3 + 1));
        for (int i = 0; i < 12; i++) step();

        // Idle bench
        idle(12);

        // CVTFI blocked six cycles after a standard op
        set_req(1, 1'b1, F_ADD, 18'h00111, 18'h00222, 5'd9);
        step();
        idle(5);
        set_req(2, 1'b1, F_CVTFI, 18'h00333, 18'h0, 5'd10);
        #1 chk("t3_blocked_ready", req_ready, 4'b0000);
        step();
        #1 chk("t3_late_ready", req_ready, 4'b0100);
        step();
        idle(10);

        // Same, with requester 3 taking the slot the CVTFI cannot
        set_req(1, 1'b1, F_ADD, 18'h00444, 18'h00555, 5'd11);
        step();
        idle(5);
        set_req(2, 1'b1, F_CVTFI, 18'h00666, 18'h0, 5'd12);
        set_req(3, 1'b1, F_ADD, 18'h00777, 18'h00888, 5'd13);
        #1 chk("t4_bypass_ready", req_ready, 4'b1000);
        step();
        set_req(3, 1'b0, F_ADD, 18'h0, 18'h0, 5'd0);
        #1 chk("t4_cvt_ready", req_ready, 4'b0100);
        step();
        idle(10);

        // Reset with several ops in flight
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'b1, F_ADD, 18'(i + 40), 18'(i + 50), 5'(i + 20));
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1 chk("rr_restart_ready", req_ready, 4'b0001);
        step();
        idle(12);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NREQ; i++) begin
                logic [4:0] f;
                f = ($urandom_range(0, 2) == 0) ? F_CVTFI : 5'($urandom_range(0, 4));
                set_req(i, ($urandom_range(0, 9) < 6), f,
                        18'($urandom), 18'($urandom), 5'($urandom));
            end
            step();
        end
        rst = 1'b0;
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
